// File: rtl/image_crypt_pkg.sv
// Shared constants, state encoding and key schedule for the frame encrypter/decrypter pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package image_crypt_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int NUM_PIXELS = 19200;
    localparam logic [7:0] KEY = 8'b1011_0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } crypt_state_e;

    // Folding the low nibble onto the high nibble; 8'hB3 yields 8'h83.
    function automatic logic [7:0] key_byte(input logic [7:0] key);
        return key ^ (key << 4);
    endfunction

endpackage

// File: rtl/crypt_delay_line.sv
// Shift register of {valid, addr} that tracks source RAM reads until the write side.
// Latency: DEPTH cycles in_vld -> out_vld; tap_* is the stage one cycle earlier.
// Backpressure: none, shifts every cycle; stored addresses hold while no valid entry passes.
module crypt_delay_line #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              pend_vld,
    output logic              tap_vld,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    always_comb begin
        vld_d  = {vld_q[DEPTH-2:0], in_vld};
        addr_d = addr_q;
        if (in_vld) begin
            addr_d[0] = in_addr;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (vld_q[i-1]) begin
                addr_d[i] = addr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    // Everything ahead of the final stage; empty means only the last write remains.
    assign pend_vld = |vld_q[DEPTH-2:0];
    assign tap_vld  = vld_q[DEPTH-2];
    assign tap_addr = addr_q[DEPTH-2];
    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/image_encrypter.sv
// Walks a source frame and writes XOR-encrypted bytes (IMAGE_ENCRYPTER_ADDR_WHITEN_EN adds address whitening).
// Latency: read_addr A -> write_en/write_addr A RD_LAT+1 cycles later; done one cycle after the last write.
// Backpressure: none; fixed-rate one pixel per cycle, start ignored unless IDLE.
module image_encrypter
    import image_crypt_pkg::*;
#(
    parameter int         ADDR_W     = image_crypt_pkg::ADDR_W,
    parameter int         DATA_W     = image_crypt_pkg::DATA_W,
    parameter int         NUM_PIXELS = image_crypt_pkg::NUM_PIXELS,
    parameter logic [7:0] KEY        = image_crypt_pkg::KEY,
    parameter int         RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] plain_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] encrypted_data
);

    localparam logic [DATA_W-1:0] K        = DATA_W'(key_byte(KEY));
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(NUM_PIXELS - 1);

    crypt_state_e      state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] enc_q, enc_d;
    logic              issue;

    logic              pend_vld;
    logic              tap_vld;
    logic [ADDR_W-1:0] tap_addr;
    logic              out_vld;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] whiten;

    crypt_delay_line #(
        .DEPTH  (RD_LAT + 1),
        .ADDR_W (ADDR_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (issue),
        .in_addr  (cnt_q[ADDR_W-1:0]),
        .pend_vld (pend_vld),
        .tap_vld  (tap_vld),
        .tap_addr (tap_addr),
        .out_vld  (out_vld),
        .out_addr (out_addr)
    );

`ifdef IMAGE_ENCRYPTER_ADDR_WHITEN_EN
    // tap_addr is the address this byte will be written to on the next cycle.
    assign whiten = DATA_W'(tap_addr);
`else
    assign whiten = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                issue = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!pend_vld) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tap_vld) begin
            enc_d = plain_data ^ K ^ whiten;
        end
        busy_d = (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign read_addr      = cnt_q[ADDR_W-1:0];
    assign write_en       = out_vld;
    assign write_addr     = out_addr;
    assign encrypted_data = enc_q;

endmodule

// File: tb/tb_image_encrypter.sv
// Three encrypter instances (16 px/lat 1, 1 px/lat 1, 8 px/lat 3) against behavioural source RAMs.
module tb_image_encrypter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [14:0] ra_s    [3];
    logic [7:0]  pd_s    [3];
    logic        we_s    [3];
    logic [14:0] wa_s    [3];
    logic [7:0]  ed_s    [3];

    always #5 clk = ~clk;

    image_encrypter #(.NUM_PIXELS(16), .RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .read_addr(ra_s[0]), .plain_data(pd_s[0]), .write_en(we_s[0]), .write_addr(wa_s[0]),
        .encrypted_data(ed_s[0]));
    image_encrypter #(.NUM_PIXELS(1), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .read_addr(ra_s[1]), .plain_data(pd_s[1]), .write_en(we_s[1]), .write_addr(wa_s[1]),
        .encrypted_data(ed_s[1]));
    image_encrypter #(.NUM_PIXELS(8), .RD_LAT(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .read_addr(ra_s[2]), .plain_data(pd_s[2]), .write_en(we_s[2]), .write_addr(wa_s[2]),
        .encrypted_data(ed_s[2]));

    // Source RAMs: data appears RD_LAT cycles after the address.
    logic [14:0] p0, p2a, p2b, p2c;
    always @(posedge clk) begin
        p0  <= ra_s[0];
        p2a <= ra_s[2];
        p2b <= p2a;
        p2c <= p2b;
    end
    assign pd_s[0] = p0[7:0];
    assign pd_s[1] = 8'hFF;
`ifdef IMAGE_ENCRYPTER_ADDR_WHITEN_EN
    assign pd_s[2] = 8'h00;
`else
    assign pd_s[2] = 8'hA0 ^ p2c[7:0];
`endif

    typedef struct {
        int addr;
        int exp;
    } vec_t;

    vec_t v0 [16];
    vec_t v2 [8];

    int total = 0;
    int bad   = 0;
    int cyc;
    int busy_n   [3];
    int done_n   [3];
    int done_cyc [3];
    int wr_n     [3];
    int wr_addr  [3][64];
    int wr_data  [3][64];
    int wr_cyc   [3][64];
    int rd_cyc   [3][16];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic clear();
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            busy_n[i] = 0; done_n[i] = 0; done_cyc[i] = -1; wr_n[i] = 0;
            for (int k = 0; k < 16; k++) rd_cyc[i][k] = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (busy_s[i]) busy_n[i]++;
            if (done_s[i]) begin
                done_n[i]++;
                done_cyc[i] = cyc;
            end
            if (we_s[i] && wr_n[i] < 64) begin
                wr_addr[i][wr_n[i]] = int'(wa_s[i]);
                wr_data[i][wr_n[i]] = int'(ed_s[i]);
                wr_cyc[i][wr_n[i]]  = cyc;
                wr_n[i]++;
            end
            if (busy_s[i] && ra_s[i] < 15'd16 && rd_cyc[i][ra_s[i][3:0]] < 0)
                rd_cyc[i][ra_s[i][3:0]] = cyc;
        end
    endtask

    task automatic check_u0(input string tag);
        chk({tag, "_writes"}, wr_n[0], 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wr_addr[0][k], v0[k].addr);
            chk($sformatf("%s_data%0d", tag, k), wr_data[0][k], v0[k].exp);
        end
        chk({tag, "_busy_cycles"}, busy_n[0], 18);
        chk({tag, "_done_count"}, done_n[0], 1);
        chk({tag, "_done_after_last"}, done_cyc[0], wr_cyc[0][15] + 1);
    endtask

    initial begin
`ifdef IMAGE_ENCRYPTER_ADDR_WHITEN_EN
        v0 = '{'{0, 8'h83}, '{1, 8'h83}, '{2, 8'h83}, '{3, 8'h83},
               '{4, 8'h83}, '{5, 8'h83}, '{6, 8'h83}, '{7, 8'h83},
               '{8, 8'h83}, '{9, 8'h83}, '{10, 8'h83}, '{11, 8'h83},
               '{12, 8'h83}, '{13, 8'h83}, '{14, 8'h83}, '{15, 8'h83}};
        v2 = '{'{0, 8'h83}, '{1, 8'h82}, '{2, 8'h81}, '{3, 8'h80},
               '{4, 8'h87}, '{5, 8'h86}, '{6, 8'h85}, '{7, 8'h84}};
`else
        v0 = '{'{0, 8'h83}, '{1, 8'h82}, '{2, 8'h81}, '{3, 8'h80},
               '{4, 8'h87}, '{5, 8'h86}, '{6, 8'h85}, '{7, 8'h84},
               '{8, 8'h8B}, '{9, 8'h8A}, '{10, 8'h89}, '{11, 8'h88},
               '{12, 8'h8F}, '{13, 8'h8E}, '{14, 8'h8D}, '{15, 8'h8C}};
        v2 = '{'{0, 8'h23}, '{1, 8'h22}, '{2, 8'h21}, '{3, 8'h20},
               '{4, 8'h27}, '{5, 8'h26}, '{6, 8'h25}, '{7, 8'h24}};
`endif
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        clear();
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), int'(busy_s[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(done_s[i]), 0);
            chk($sformatf("rst_we%0d", i), int'(we_s[i]), 0);
            chk($sformatf("rst_ra%0d", i), int'(ra_s[i]), 0);
            chk($sformatf("rst_wa%0d", i), int'(wa_s[i]), 0);
            chk($sformatf("rst_ed%0d", i), int'(ed_s[i]), 0);
        end
        rst_n = 1'b1;
        step();

        // All three frames at once; stray starts in READ (u0), DONE (u1), DRAIN (u2).
        clear();
        for (int i = 0; i < 3; i++) start_s[i] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        chk("first_cycle_busy", int'(busy_s[0]), 1);
        chk("first_cycle_ra", int'(ra_s[0]), 0);
        for (int j = 1; j <= 40; j++) begin
            start_s[0] = (j == 6);
            start_s[1] = (j == 4);
            start_s[2] = (j == 10);
            step();
        end
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        check_u0("f16");
        chk("f16_hold_wa", int'(wa_s[0]), 15);
        chk("f16_hold_ed", int'(ed_s[0]), v0[15].exp);
        chk("f16_idle_we", int'(we_s[0]), 0);

        chk("f1_writes", wr_n[1], 1);
        chk("f1_addr", wr_addr[1][0], 0);
        chk("f1_data", wr_data[1][0], 8'h7C);
        chk("f1_busy_cycles", busy_n[1], 3);
        chk("f1_done_count", done_n[1], 1);
        chk("f1_done_after_last", done_cyc[1], wr_cyc[1][0] + 1);

        chk("f8_writes", wr_n[2], 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f8_addr%0d", k), wr_addr[2][k], v2[k].addr);
            chk($sformatf("f8_data%0d", k), wr_data[2][k], v2[k].exp);
            chk($sformatf("f8_lag%0d", k), wr_cyc[2][k] - rd_cyc[2][k], 4);
        end
        chk("f8_busy_cycles", busy_n[2], 12);
        chk("f8_done_count", done_n[2], 1);
        chk("f8_done_after_last", done_cyc[2], wr_cyc[2][7] + 1);

        // start held high on the 1-pixel instance: frames repeat every 5 cycles.
        clear();
        start_s[1] = 1'b1;
        repeat (12) step();
        start_s[1] = 1'b0;
        repeat (10) step();
        chk("held_writes", wr_n[1], 3);
        chk("held_done_count", done_n[1], 3);
        chk("held_period_a", wr_cyc[1][1] - wr_cyc[1][0], 5);
        chk("held_period_b", wr_cyc[1][2] - wr_cyc[1][1], 5);

        // Reset asserted in the cycle showing the 6th write.
        clear();
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        for (int g = 0; g < 40 && wr_n[0] < 6; g++) step();
        chk("mid_sixth_write_seen", wr_n[0], 6);
        chk("mid_sixth_write_addr", int'(wa_s[0]), 5);
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", int'(busy_s[0]), 0);
        chk("mid_rst_done", int'(done_s[0]), 0);
        chk("mid_rst_we", int'(we_s[0]), 0);
        chk("mid_rst_ra", int'(ra_s[0]), 0);
        chk("mid_rst_wa", int'(wa_s[0]), 0);
        chk("mid_rst_ed", int'(ed_s[0]), 0);
        rst_n = 1'b1;
        clear();
        repeat (30) step();
        chk("post_rst_writes", wr_n[0], 0);
        chk("post_rst_done", done_n[0], 0);
        chk("post_rst_busy", busy_n[0], 0);

        clear();
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        repeat (30) step();
        check_u0("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
